// File: rtl/data_mem_mmio.sv
// data_mem_mmio: MEM-stage data RAM plus memory-mapped LEDs, switches, compare timer and 8N1 UART TX
//   CLOCK        in   system clock, all state on rising edge
//   RST_n        in   synchronous active-low reset
//   ena_wr       in   store strobe
//   ena_rd       in   load strobe
//   alu_out_ext  in   byte address (bits [1:0] ignored)
//   dataram_wr   in   store data
//   dataram_rd   out  load data, combinational, 0 when ena_rd=0
//   switches     in   asynchronous board switches
//   leds         out  LED register
//   uart_tx      out  serial line, idle high
//   timer_irq    out  sticky timer match flag
module data_mem_mmio #(
    parameter int          RAM_ADDR_W    = 10,
    parameter int          LED_W         = 10,
    parameter int          SW_W          = 10,
    parameter int          CLKS_PER_BIT  = 434,
    parameter logic [31:0] TIMER_CMP_RST = 32'hFFFF_FFFF
) (
    input  logic             CLOCK,
    input  logic             RST_n,
    input  logic             ena_wr,
    input  logic             ena_rd,
    input  logic [31:0]      alu_out_ext,
    input  logic [31:0]      dataram_wr,
    output logic [31:0]      dataram_rd,
    input  logic [SW_W-1:0]  switches,
    output logic [LED_W-1:0] leds,
    output logic             uart_tx,
    output logic             timer_irq
);
    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        SEL_LEDS   = 3'd0;
    localparam logic [2:0]        SEL_SW     = 3'd1;
    localparam logic [2:0]        SEL_TCOUNT = 3'd2;
    localparam logic [2:0]        SEL_TCMP   = 3'd3;
    localparam logic [2:0]        SEL_STATUS = 3'd4;
    localparam logic [2:0]        SEL_UART   = 3'd5;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

    logic [31:0]           mem [0:2**RAM_ADDR_W-1];
    logic                  is_ram, is_io;
    logic [2:0]            sel;
    logic [RAM_ADDR_W-1:0] ram_idx;
    logic                  wr_ram, wr_leds, wr_tcount, wr_tcmp, wr_status, wr_uart;
    logic [31:0]           io_rdata;
    logic                  unused_addr_bits;

    logic [LED_W-1:0]      leds_q, leds_d;
    logic [SW_W-1:0]       sw_meta_q, sw_sync_q;
    logic [31:0]           tcount_q, tcount_d, tcmp_q, tcmp_d;
    logic                  tflag_q, tflag_d, tmatch;

    uart_state_e           state_q, state_d;
    logic [BAUD_W-1:0]     baud_q, baud_d;
    logic [2:0]            bit_q, bit_d;
    logic [7:0]            byte_q, byte_d;
    logic                  baud_done, busy;

    assign is_ram  = alu_out_ext[31:16] == 16'h0000;
    assign is_io   = alu_out_ext[31:16] == 16'h1000;
    assign sel     = alu_out_ext[4:2];
    assign ram_idx = alu_out_ext[RAM_ADDR_W+1:2];
    // Low byte-offset bits and the gap between RAM index and region tag only alias.
    assign unused_addr_bits = ^{alu_out_ext[15:5], alu_out_ext[1:0]};

    assign wr_ram    = ena_wr && is_ram;
    assign wr_leds   = ena_wr && is_io && sel == SEL_LEDS;
    assign wr_tcount = ena_wr && is_io && sel == SEL_TCOUNT;
    assign wr_tcmp   = ena_wr && is_io && sel == SEL_TCMP;
    assign wr_status = ena_wr && is_io && sel == SEL_STATUS;
    assign wr_uart   = ena_wr && is_io && sel == SEL_UART;

    // Asynchronous RAM read: the core captures load data at the end of the MEM cycle.
    always_ff @(posedge CLOCK) begin
        if (wr_ram)
            mem[ram_idx] <= dataram_wr;
    end

    always_comb begin
        io_rdata = '0;
        case (sel)
            SEL_LEDS:   io_rdata = 32'(leds_q);
            SEL_SW:     io_rdata = 32'(sw_sync_q);
            SEL_TCOUNT: io_rdata = tcount_q;
            SEL_TCMP:   io_rdata = tcmp_q;
            SEL_STATUS: io_rdata = {30'd0, busy, tflag_q};
            default:    io_rdata = '0;
        endcase
    end

    assign dataram_rd = !ena_rd ? '0 : is_ram ? mem[ram_idx] : is_io ? io_rdata : '0;

    // A TCOUNT write wins over both increment and match-clear; a match still raises the flag,
    // and a match beats a same-cycle write-1-clear.
    assign tmatch = tcount_q == tcmp_q;

    always_comb begin
        leds_d   = wr_leds ? dataram_wr[LED_W-1:0] : leds_q;
        tcount_d = wr_tcount ? dataram_wr : tmatch ? '0 : tcount_q + 32'd1;
        tcmp_d   = wr_tcmp ? dataram_wr : tcmp_q;
        tflag_d  = tmatch ? 1'b1 : (wr_status && dataram_wr[0]) ? 1'b0 : tflag_q;
    end

    always_ff @(posedge CLOCK) begin
        if (!RST_n) begin
            leds_q    <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            tcount_q  <= '0;
            tcmp_q    <= TIMER_CMP_RST;
            tflag_q   <= 1'b0;
        end else begin
            leds_q    <= leds_d;
            sw_meta_q <= switches;
            sw_sync_q <= sw_meta_q;
            tcount_q  <= tcount_d;
            tcmp_q    <= tcmp_d;
            tflag_q   <= tflag_d;
        end
    end

    assign leds      = leds_q;
    assign timer_irq = tflag_q;

    assign baud_done = baud_q == BAUD_LAST;

    always_ff @(posedge CLOCK) begin
        if (!RST_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = wr_uart ? START : IDLE;
            START:   state_d = baud_done ? DATA : START;
            DATA:    state_d = (baud_done && bit_q == 3'd7) ? STOP : DATA;
            STOP:    state_d = baud_done ? IDLE : STOP;
            default: state_d = IDLE;
        endcase
    end

    // Baud counter restarts in IDLE so every START lasts exactly CLKS_PER_BIT cycles.
    always_comb begin
        baud_d = (state_q == IDLE || baud_done) ? '0 : baud_q + BAUD_W'(1);
        bit_d  = state_q != DATA ? 3'd0 : baud_done ? bit_q + 3'd1 : bit_q;
        byte_d = (state_q == IDLE && wr_uart) ? dataram_wr[7:0] : byte_q;
    end

    always_ff @(posedge CLOCK) begin
        if (!RST_n) begin
            baud_q <= '0;
            bit_q  <= '0;
            byte_q <= '0;
        end else begin
            baud_q <= baud_d;
            bit_q  <= bit_d;
            byte_q <= byte_d;
        end
    end

    always_comb begin
        busy    = state_q != IDLE;
        uart_tx = state_q == START ? 1'b0 : state_q == DATA ? byte_q[bit_q] : 1'b1;
    end
endmodule

// File: tb/tb_data_mem_mmio.sv
// tb_data_mem_mmio: self-checking bench for data_mem_mmio with CLKS_PER_BIT=4
module tb_data_mem_mmio;
    localparam int          CPB  = 4;
    localparam logic [31:0] IO   = 32'h1000_0000;
    localparam logic [31:0] LEDS = IO + 32'h00;
    localparam logic [31:0] SW   = IO + 32'h04;
    localparam logic [31:0] TCNT = IO + 32'h08;
    localparam logic [31:0] TCMP = IO + 32'h0C;
    localparam logic [31:0] STAT = IO + 32'h10;
    localparam logic [31:0] UTX  = IO + 32'h14;

    logic        CLOCK = 1'b0;
    logic        RST_n = 1'b0;
    logic        ena_wr = 1'b0;
    logic        ena_rd = 1'b0;
    logic [31:0] alu_out_ext = '0;
    logic [31:0] dataram_wr = '0;
    logic [31:0] dataram_rd;
    logic [9:0]  switches = '0;
    logic [9:0]  leds;
    logic        uart_tx;
    logic        timer_irq;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] exp;
        string       name;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        bit          wr;
        bit          rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          chk;
        logic [31:0] exp;
        string       name;
    } vec_t;
    vec_t vecs[$];

    data_mem_mmio #(.CLKS_PER_BIT(CPB)) dut (
        .CLOCK(CLOCK),
        .RST_n(RST_n),
        .ena_wr(ena_wr),
        .ena_rd(ena_rd),
        .alu_out_ext(alu_out_ext),
        .dataram_wr(dataram_wr),
        .dataram_rd(dataram_rd),
        .switches(switches),
        .leds(leds),
        .uart_tx(uart_tx),
        .timer_irq(timer_irq)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One bus cycle: drive at the falling edge, compare the combinational read 2 ns later.
    task automatic req(input bit wr, input bit rd, input logic [31:0] addr, input logic [31:0] wdata,
                       input bit chk, input logic [31:0] exp, input string name);
        sb_t e;
        @(negedge CLOCK);
        ena_wr = wr;
        ena_rd = rd;
        alu_out_ext = addr;
        dataram_wr = wdata;
        if (chk) sb.push_back('{exp, name});
        #2;
        if (chk) begin
            e = sb.pop_front();
            check(e.name, dataram_rd, e.exp);
        end
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
        req(1'b0, 1'b1, addr, 32'd0, 1'b1, exp, name);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        req(1'b1, 1'b0, addr, data, 1'b0, 32'd0, "");
    endtask

    task automatic add(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d,
                       input bit c, input logic [31:0] e, input string n);
        vecs.push_back('{w, r, a, d, c, e, n});
    endtask

    initial begin
        logic [9:0] frame;
        frame = {1'b1, 8'hA5, 1'b0};

        add(1, 0, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h0, "");
        add(0, 1, 32'h0000_0010, 32'h0,         1, 32'hDEAD_BEEF, "ram_rd");
        add(0, 1, 32'h0000_1010, 32'h0,         1, 32'hDEAD_BEEF, "ram_alias");
        add(0, 0, 32'h0000_0010, 32'h0,         1, 32'h0,         "rd_gate");
        add(1, 0, LEDS,          32'h0000_03FF, 0, 32'h0,         "");
        add(0, 1, LEDS,          32'h0,         1, 32'h0000_03FF, "leds_rd");
        add(0, 1, 32'h2000_0000, 32'h0,         1, 32'h0,         "unmapped_rd");
        add(1, 0, 32'h0000_0000, 32'hCAFE_0000, 0, 32'h0,         "");
        add(1, 0, 32'h2000_0000, 32'h1234_5678, 0, 32'h0,         "");
        add(0, 1, 32'h0000_0000, 32'h0,         1, 32'hCAFE_0000, "unmapped_wr");
        add(0, 1, IO + 32'h18,   32'h0,         1, 32'h0,         "io_hole");
        add(0, 1, UTX,           32'h0,         1, 32'h0,         "uart_rd");
        add(0, 1, STAT,          32'h0,         1, 32'h0,         "status_idle");
        add(1, 0, 32'h0000_0020, 32'h1,         0, 32'h0,         "");
        add(1, 1, 32'h0000_0020, 32'h2,         1, 32'h1,         "rw_old");
        add(0, 1, 32'h0000_0020, 32'h0,         1, 32'h2,         "rw_new");

        repeat (2) @(posedge CLOCK);
        #1 RST_n = 1'b1;
        check("rst_leds", 32'(leds), 32'h0);
        check("rst_tx", 32'(uart_tx), 32'h1);
        check("rst_irq", 32'(timer_irq), 32'h0);
        rd(TCMP, 32'hFFFF_FFFF, "rst_tcmp");

        foreach (vecs[i])
            req(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].chk, vecs[i].exp, vecs[i].name);
        check("leds_out", 32'(leds), 32'h3FF);

        switches = 10'h155;
        rd(SW, 32'h0, "sw_1cyc");
        rd(SW, 32'h155, "sw_2cyc");

        wr(TCMP, 32'd5);
        wr(TCNT, 32'd0);
        for (int i = 0; i <= 6; i++) begin
            rd(TCNT, i <= 5 ? 32'(i) : 32'd0, "tcount_seq");
            check("irq_seq", 32'(timer_irq), 32'(i == 6));
        end
        wr(STAT, 32'd1);
        rd(STAT, 32'd0, "status_clr");
        check("irq_clr", 32'(timer_irq), 32'h0);
        req(0, 0, 0, 0, 0, 0, "");
        req(0, 0, 0, 0, 0, 0, "");
        wr(TCNT, 32'd3);
        rd(TCNT, 32'd3, "tcount_load_on_match");
        check("irq_on_load", 32'(timer_irq), 32'h1);
        wr(STAT, 32'd1);
        wr(STAT, 32'd1);
        check("irq_cleared", 32'(timer_irq), 32'h0);
        rd(TCNT, 32'd0, "tcount_wrap");
        check("set_wins", 32'(timer_irq), 32'h1);
        wr(TCMP, 32'hFFFF_FFFF);
        wr(STAT, 32'd1);
        rd(STAT, 32'd0, "status_pre_uart");

        wr(UTX, 32'hA5);
        check("tx_idle", 32'(uart_tx), 32'h1);
        for (int k = 1; k <= 41; k++) begin
            if (k == 20) wr(UTX, 32'h00);
            else rd(STAT, k <= 40 ? 32'h2 : 32'h0, "uart_busy");
            check("uart_tx", 32'(uart_tx), k <= 40 ? 32'(frame[(k - 1) / CPB]) : 32'h1);
        end

        wr(UTX, 32'h00);
        for (int m = 1; m <= 11; m++) rd(STAT, 32'h2, "busy_pre_rst");
        @(negedge CLOCK);
        RST_n = 1'b0;
        ena_rd = 1'b0;
        ena_wr = 1'b0;
        #2 check("tx_mid_frame", 32'(uart_tx), 32'h0);
        rd(STAT, 32'h0, "busy_after_rst");
        check("tx_after_rst", 32'(uart_tx), 32'h1);
        check("leds_after_rst", 32'(leds), 32'h0);
        RST_n = 1'b1;
        rd(32'h0000_0010, 32'hDEAD_BEEF, "ram_kept");
        req(0, 0, 0, 0, 0, 0, "");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
